// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared widths, opcode constants and the issued-op record
// used by the ALU execute stage and anything else that decodes OpBus.
// No ports; imported with "import alu_exec_pkg::*".
package alu_exec_pkg;

  localparam int DATA_W = 32;  // DataBus width
  localparam int ROB_W  = 4;   // ROBBus width
  localparam int OP_W   = 6;   // OpBus width

  localparam logic True    = 1'b1;
  localparam logic False   = 1'b0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd11;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd13;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd15;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd16;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd17;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd18;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd19;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd20;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd21;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd22;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd23;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd24;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd25;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd26;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd27;
  localparam logic [OP_W-1:0] OP_OR    = 6'd28;
  localparam logic [OP_W-1:0] OP_AND   = 6'd29;

  // One issued op as seen on the ALU_* lines; also the hold-buffer format.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] pc;
    logic [ROB_W-1:0]  tag;
  } issue_t;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue bus from the reservation station (ALU_*) and the
// registered ALU common data bus (CDB_ALU_*).
// master = RS/consumer side (drives ALU_*), slave = execute stage.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic              ALU_S;
  logic [OP_W-1:0]   ALU_Op;
  logic [DATA_W-1:0] ALU_Vj;
  logic [DATA_W-1:0] ALU_Vk;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_pc;
  logic [ROB_W-1:0]  ALU_Reorder;

  logic              CDB_ALU_S;
  logic [ROB_W-1:0]  CDB_ALU_Reorder;
  logic [DATA_W-1:0] CDB_ALU_Value;
  logic              CDB_ALU_Jump;
  logic [DATA_W-1:0] CDB_ALU_Target;

  modport master (
    output ALU_S, ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder,
    input  CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value, CDB_ALU_Jump, CDB_ALU_Target
  );

  modport slave (
    input  ALU_S, ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder,
    output CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value, CDB_ALU_Jump, CDB_ALU_Target
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational integer/branch/jump datapath.
// Ports: op, vj, vk, a (immediate), pc in; value (rd), jump (taken), target out.
// Target is forced to 0 whenever jump is 0, so not-taken branches look like plain ALU ops.
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] vj,
  input  logic [DATA_W-1:0] vk,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] value,
  output logic              jump,
  output logic [DATA_W-1:0] target
);

  logic [DATA_W-1:0] pc_a;
  logic [DATA_W-1:0] pc_4;
  logic [DATA_W-1:0] jalr_sum;
  logic [4:0]        sh_a;
  logic [4:0]        sh_k;
  logic              eq;
  logic              lt;
  logic              ltu;
  logic [DATA_W-1:0] raw_target;

  assign pc_a     = pc + a;
  assign pc_4     = pc + DATA_W'(4);
  assign jalr_sum = vj + a;
  assign sh_a     = a[4:0];
  assign sh_k     = vk[4:0];
  assign eq       = (vj == vk);
  assign lt       = ($signed(vj) < $signed(vk));
  assign ltu      = (vj < vk);

  always_comb begin
    value      = '0;
    jump       = 1'b0;
    raw_target = '0;
    case (op)
      OP_LUI:   value = a;
      OP_AUIPC: value = pc_a;
      OP_JAL:   begin value = pc_4; jump = 1'b1; raw_target = pc_a; end
      // JALR clears bit 0 of the computed address
      OP_JALR:  begin value = pc_4; jump = 1'b1; raw_target = {jalr_sum[DATA_W-1:1], 1'b0}; end
      OP_BEQ:   begin jump = eq;   raw_target = pc_a; end
      OP_BNE:   begin jump = !eq;  raw_target = pc_a; end
      OP_BLT:   begin jump = lt;   raw_target = pc_a; end
      OP_BGE:   begin jump = !lt;  raw_target = pc_a; end
      OP_BLTU:  begin jump = ltu;  raw_target = pc_a; end
      OP_BGEU:  begin jump = !ltu; raw_target = pc_a; end
      OP_ADDI:  value = jalr_sum;
      OP_SLTI:  value = {{(DATA_W-1){1'b0}}, ($signed(vj) < $signed(a))};
      OP_SLTIU: value = {{(DATA_W-1){1'b0}}, (vj < a)};
      OP_XORI:  value = vj ^ a;
      OP_ORI:   value = vj | a;
      OP_ANDI:  value = vj & a;
      OP_SLLI:  value = vj << sh_a;
      OP_SRLI:  value = vj >> sh_a;
      OP_SRAI:  value = $unsigned($signed(vj) >>> sh_a);
      OP_ADD:   value = vj + vk;
      OP_SUB:   value = vj - vk;
      OP_SLL:   value = vj << sh_k;
      OP_SLT:   value = {{(DATA_W-1){1'b0}}, lt};
      OP_SLTU:  value = {{(DATA_W-1){1'b0}}, ltu};
      OP_XOR:   value = vj ^ vk;
      OP_SRL:   value = vj >> sh_k;
      OP_SRA:   value = $unsigned($signed(vj) >>> sh_k);
      OP_OR:    value = vj | vk;
      OP_AND:   value = vj & vk;
      default:  ;
    endcase
  end

  assign target = jump ? raw_target : '0;

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage behind the RS; one op in, one registered CDB result out per cycle.
// Ports: clk, rst (sync, active-high), rdy (global stall when low), clr (flush), bus (alu_exec_if.slave).
// Latency 1 edge; an op arriving while rdy is low parks in a one-entry hold buffer.
// Optional macro ALU_EXEC_PERF_EN adds perf_ops / perf_taken result counters.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       clr,
  alu_exec_if.slave  bus
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_taken
`endif
);

  issue_t            live;
  issue_t            hold;
  issue_t            src;
  logic              hold_vld;
  logic              fire;

  logic [DATA_W-1:0] c_value;
  logic              c_jump;
  logic [DATA_W-1:0] c_target;

  logic              cdb_s;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_jump;
  logic [DATA_W-1:0] cdb_target;

  always_comb begin
    live     = '0;
    live.op  = bus.ALU_Op;
    live.vj  = bus.ALU_Vj;
    live.vk  = bus.ALU_Vk;
    live.a   = bus.ALU_A;
    live.pc  = bus.ALU_pc;
    live.tag = bus.ALU_Reorder;
  end

  // A parked op always wins; the RS holds off issuing while it is parked.
  assign src  = hold_vld ? hold : live;
  assign fire = rdy && !clr && (hold_vld || bus.ALU_S);

  alu_core u_core (
    .op     (src.op),
    .vj     (src.vj),
    .vk     (src.vk),
    .a      (src.a),
    .pc     (src.pc),
    .value  (c_value),
    .jump   (c_jump),
    .target (c_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_s      <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_jump   <= 1'b0;
      cdb_target <= '0;
      hold_vld   <= 1'b0;
      hold       <= '0;
    end else if (clr) begin
      // Flush only kills validity; payload registers keep their last values.
      cdb_s    <= 1'b0;
      hold_vld <= 1'b0;
    end else if (!rdy) begin
      // Outputs frozen; a second op while already parked is dropped.
      if (bus.ALU_S && !hold_vld) begin
        hold     <= live;
        hold_vld <= 1'b1;
      end
    end else begin
      cdb_s    <= hold_vld || bus.ALU_S;
      hold_vld <= 1'b0;
      if (fire) begin
        cdb_tag    <= src.tag;
        cdb_value  <= c_value;
        cdb_jump   <= c_jump;
        cdb_target <= c_target;
      end
    end
  end

`ifdef ALU_EXEC_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_taken <= '0;
    end else if (fire) begin
      perf_ops <= perf_ops + 32'd1;
      if (c_jump) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

  assign bus.CDB_ALU_S       = cdb_s;
  assign bus.CDB_ALU_Reorder = cdb_tag;
  assign bus.CDB_ALU_Value   = cdb_value;
  assign bus.CDB_ALU_Jump    = cdb_jump;
  assign bus.CDB_ALU_Target  = cdb_target;

endmodule
